ma_dataphase: RTL and testbench

Memory-access (MA) stage data-phase controller that sits directly downstream of the execute stage. It consumes the EX→MA instruction register outputs (valid, destination, function, result/address) and completes the data phase of the AHB3-Lite transfer that EX started. It aligns and sign-extends load data and registers the final result into the MA→WB register. It also raises stall toward EX while a data phase is pending.

---
 rtl/ma_dataphase_if.sv | 53 +++++
 rtl/ma_dataphase.sv | 237 +++++++++++++++++++++++
 tb/tb_ma_dataphase.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ma_dataphase_if.sv
// ---------------------------------------------------------------------------
// ma_dataphase_if
// Groups every non-clock signal of the MA data-phase controller:
//   EX->MA register outputs : s_exma_valid_i, s_exma_load_i, s_exma_store_i,
//                             s_exma_f_i, s_exma_rd_i, s_exma_val_i,
//                             s_exma_tstrd_i
//   pipeline control        : s_flush_i, s_stall_wb_i, s_stall_o
//   AHB3-Lite data phase    : s_d_hready_i, s_d_hresp_i, s_d_hrdata_i
//   MA->WB register         : s_mawb_valid_o, s_mawb_rd_o, s_mawb_we_o,
//                             s_mawb_val_o, s_mawb_err_o
//   diagnostics             : s_errcnt_o (saturating bus-error count)
// The _i/_o suffixes are relative to the controller, which takes the slave
// modport; the surrounding pipeline / bench takes the master modport.
// ---------------------------------------------------------------------------
interface ma_dataphase_if #(
    parameter int ERRCNT_W = 8
);
    logic                s_flush_i;
    logic                s_stall_wb_i;
    logic                s_exma_valid_i;
    logic                s_exma_load_i;
    logic                s_exma_store_i;
    logic [2:0]          s_exma_f_i;
    logic [4:0]          s_exma_rd_i;
    logic [31:0]         s_exma_val_i;
    logic                s_exma_tstrd_i;
    logic                s_d_hready_i;
    logic                s_d_hresp_i;
    logic [31:0]         s_d_hrdata_i;
    logic                s_stall_o;
    logic                s_mawb_valid_o;
    logic [4:0]          s_mawb_rd_o;
    logic                s_mawb_we_o;
    logic [31:0]         s_mawb_val_o;
    logic                s_mawb_err_o;
    logic [ERRCNT_W-1:0] s_errcnt_o;

    modport slave (
        input  s_flush_i, s_stall_wb_i, s_exma_valid_i, s_exma_load_i,
               s_exma_store_i, s_exma_f_i, s_exma_rd_i, s_exma_val_i,
               s_exma_tstrd_i, s_d_hready_i, s_d_hresp_i, s_d_hrdata_i,
        output s_stall_o, s_mawb_valid_o, s_mawb_rd_o, s_mawb_we_o,
               s_mawb_val_o, s_mawb_err_o, s_errcnt_o
    );

    modport master (
        output s_flush_i, s_stall_wb_i, s_exma_valid_i, s_exma_load_i,
               s_exma_store_i, s_exma_f_i, s_exma_rd_i, s_exma_val_i,
               s_exma_tstrd_i, s_d_hready_i, s_d_hresp_i, s_d_hrdata_i,
        input  s_stall_o, s_mawb_valid_o, s_mawb_rd_o, s_mawb_we_o,
               s_mawb_val_o, s_mawb_err_o, s_errcnt_o
    );
endinterface

// File: rtl/ma_dataphase.sv
// ---------------------------------------------------------------------------
// ma_dataphase
// Memory-access stage data-phase controller. Completes the AHB3-Lite data
// phase started by EX, aligns/sign-extends load data, writes the MA->WB
// register and stalls EX while a data phase is outstanding.
// Ports:
//   s_clk_i    : clock
//   s_resetn_i : asynchronous active-low reset
//   bus        : ma_dataphase_if.slave (EX->MA inputs, AHB data phase,
//                MA->WB outputs, stall, error counter)
// ---------------------------------------------------------------------------
module ma_dataphase #(
    parameter int          ERRCNT_W   = 8,
    parameter logic [31:0] RST_PC_VAL = 32'h0000_0000
) (
    input  logic          s_clk_i,
    input  logic          s_resetn_i,
    ma_dataphase_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ERR1 = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [2:0]          f_q, f_d;
    logic [4:0]          rd_q, rd_d;
    logic                load_q, load_d;
    logic                drop_q, drop_d;

    logic                pend_q, pend_d;
    logic [4:0]          pend_rd_q, pend_rd_d;
    logic                pend_we_q, pend_we_d;
    logic [31:0]         pend_val_q, pend_val_d;
    logic                pend_err_q, pend_err_d;

    logic                valid_q, valid_d;
    logic [4:0]          mrd_q, mrd_d;
    logic                we_q, we_d;
    logic [31:0]         val_q, val_d;
    logic                err_q, err_d;
    logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

    logic                lsu_start, in_data, in_phase, complete, bus_err, drop_eff;
    logic                nonlsu;
    logic [31:0]         cur_addr;
    logic [2:0]          cur_f;
    logic [4:0]          cur_rd;
    logic                cur_load;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [31:0]         load_data, res_val;
    logic                res_we;

    // The tstrd cycle is already the first data-phase cycle, so an LSU start
    // is handled exactly like being in DATA. While a held result waits in the
    // pending buffer, the EX register still shows that same instruction and
    // must not be started again.
    always_comb begin
        lsu_start = (state_q == IDLE) & ~pend_q & bus.s_exma_valid_i &
                    (bus.s_exma_load_i | bus.s_exma_store_i) & bus.s_exma_tstrd_i;
        nonlsu    = (state_q == IDLE) & ~pend_q & bus.s_exma_valid_i &
                    ~bus.s_exma_load_i & ~bus.s_exma_store_i;
        in_data   = lsu_start | (state_q == DATA);
        in_phase  = lsu_start | (state_q != IDLE);
        if (state_q == IDLE) begin
            cur_addr = bus.s_exma_val_i;
            cur_f    = bus.s_exma_f_i;
            cur_rd   = bus.s_exma_rd_i;
            cur_load = bus.s_exma_load_i;
        end else begin
            cur_addr = addr_q;
            cur_f    = f_q;
            cur_rd   = rd_q;
            cur_load = load_q;
        end
    end

    always_comb begin
        byte_sel = bus.s_d_hrdata_i[7:0];
        case (cur_addr[1:0])
            2'd1:    byte_sel = bus.s_d_hrdata_i[15:8];
            2'd2:    byte_sel = bus.s_d_hrdata_i[23:16];
            2'd3:    byte_sel = bus.s_d_hrdata_i[31:24];
            default: byte_sel = bus.s_d_hrdata_i[7:0];
        endcase
        half_sel = cur_addr[1] ? bus.s_d_hrdata_i[31:16] : bus.s_d_hrdata_i[15:0];
        case (cur_f[1:0])
            2'b00:   load_data = {{24{byte_sel[7] & ~cur_f[2]}}, byte_sel};
            2'b01:   load_data = {{16{half_sel[15] & ~cur_f[2]}}, half_sel};
            default: load_data = bus.s_d_hrdata_i;
        endcase
    end

    // hready=1 with hresp=1 in the first data-phase cycle is not legal AHB;
    // it is taken as an error completion so the FSM can never lock up.
    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        bus_err  = 1'b0;
        if (in_data) begin
            if (bus.s_d_hready_i) begin
                complete = 1'b1;
                bus_err  = bus.s_d_hresp_i;
                state_d  = IDLE;
            end else if (bus.s_d_hresp_i) begin
                state_d  = ERR1;
            end else begin
                state_d  = DATA;
            end
        end else if (state_q == ERR1) begin
            if (bus.s_d_hready_i & bus.s_d_hresp_i) begin
                complete = 1'b1;
                bus_err  = 1'b1;
                state_d  = IDLE;
            end
        end else if (nonlsu) begin
            complete = 1'b1;
        end
    end

    assign bus.s_stall_o = (in_phase & ~complete) | bus.s_stall_wb_i;

    always_comb begin
        drop_eff = drop_q | bus.s_flush_i;
        drop_d   = (in_phase & ~complete) ? drop_eff : 1'b0;
        addr_d   = lsu_start ? bus.s_exma_val_i  : addr_q;
        f_d      = lsu_start ? bus.s_exma_f_i    : f_q;
        rd_d     = lsu_start ? bus.s_exma_rd_i   : rd_q;
        load_d   = lsu_start ? bus.s_exma_load_i : load_q;
        if (in_phase & (bus_err | ~cur_load)) begin
            res_val = cur_addr;
        end else if (in_phase) begin
            res_val = load_data;
        end else begin
            res_val = bus.s_exma_val_i;
        end
        res_we = ~bus_err & (cur_rd != 5'd0) & (~in_phase | cur_load);
    end

    // MA->WB register, pending buffer for LSU results completed under a WB
    // stall, and the saturating error counter (counts even dropped errors).
    always_comb begin
        valid_d    = valid_q;
        mrd_d      = mrd_q;
        we_d       = we_q;
        val_d      = val_q;
        err_d      = err_q;
        pend_d     = pend_q;
        pend_rd_d  = pend_rd_q;
        pend_we_d  = pend_we_q;
        pend_val_d = pend_val_q;
        pend_err_d = pend_err_q;
        errcnt_d   = errcnt_q;
        if (complete & bus_err & ~(&errcnt_q)) begin
            errcnt_d = errcnt_q + ERRCNT_W'(1);
        end
        if (~bus.s_stall_wb_i) begin
            pend_d = 1'b0;
            if (pend_q) begin
                valid_d = ~bus.s_flush_i;
                mrd_d   = pend_rd_q;
                we_d    = pend_we_q & ~bus.s_flush_i;
                val_d   = pend_val_q;
                err_d   = pend_err_q;
            end else if (complete & ~drop_eff) begin
                valid_d = 1'b1;
                mrd_d   = cur_rd;
                we_d    = res_we;
                val_d   = res_val;
                err_d   = bus_err;
            end else begin
                valid_d = 1'b0;
                we_d    = 1'b0;
            end
        end else if (pend_q) begin
            pend_d = ~bus.s_flush_i;
        end else if (complete & in_phase & ~drop_eff) begin
            pend_d     = 1'b1;
            pend_rd_d  = cur_rd;
            pend_we_d  = res_we;
            pend_val_d = res_val;
            pend_err_d = bus_err;
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_q    <= IDLE;
            addr_q     <= 32'h0;
            f_q        <= 3'h0;
            rd_q       <= 5'h0;
            load_q     <= 1'b0;
            drop_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_rd_q  <= 5'h0;
            pend_we_q  <= 1'b0;
            pend_val_q <= 32'h0;
            pend_err_q <= 1'b0;
            valid_q    <= 1'b0;
            mrd_q      <= 5'h0;
            we_q       <= 1'b0;
            val_q      <= RST_PC_VAL;
            err_q      <= 1'b0;
            errcnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            f_q        <= f_d;
            rd_q       <= rd_d;
            load_q     <= load_d;
            drop_q     <= drop_d;
            pend_q     <= pend_d;
            pend_rd_q  <= pend_rd_d;
            pend_we_q  <= pend_we_d;
            pend_val_q <= pend_val_d;
            pend_err_q <= pend_err_d;
            valid_q    <= valid_d;
            mrd_q      <= mrd_d;
            we_q       <= we_d;
            val_q      <= val_d;
            err_q      <= err_d;
            errcnt_q   <= errcnt_d;
        end
    end

    assign bus.s_mawb_valid_o = valid_q;
    assign bus.s_mawb_rd_o    = mrd_q;
    assign bus.s_mawb_we_o    = we_q;
    assign bus.s_mawb_val_o   = val_q;
    assign bus.s_mawb_err_o   = err_q;
    assign bus.s_errcnt_o     = errcnt_q;

endmodule

// File: tb/tb_ma_dataphase.sv
// ---------------------------------------------------------------------------
// tb_ma_dataphase
// Directed bench for ma_dataphase. Two instances share one stimulus: an
// 8-bit error counter instance (main checks) and a 2-bit one (saturation).
// ---------------------------------------------------------------------------
module tb_ma_dataphase;

    logic clk = 1'b0;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ma_dataphase_if #(.ERRCNT_W(8)) bus8 ();
    ma_dataphase_if #(.ERRCNT_W(2)) bus2 ();

    assign bus2.s_flush_i      = bus8.s_flush_i;
    assign bus2.s_stall_wb_i   = bus8.s_stall_wb_i;
    assign bus2.s_exma_valid_i = bus8.s_exma_valid_i;
    assign bus2.s_exma_load_i  = bus8.s_exma_load_i;
    assign bus2.s_exma_store_i = bus8.s_exma_store_i;
    assign bus2.s_exma_f_i     = bus8.s_exma_f_i;
    assign bus2.s_exma_rd_i    = bus8.s_exma_rd_i;
    assign bus2.s_exma_val_i   = bus8.s_exma_val_i;
    assign bus2.s_exma_tstrd_i = bus8.s_exma_tstrd_i;
    assign bus2.s_d_hready_i   = bus8.s_d_hready_i;
    assign bus2.s_d_hresp_i    = bus8.s_d_hresp_i;
    assign bus2.s_d_hrdata_i   = bus8.s_d_hrdata_i;

    ma_dataphase #(.ERRCNT_W(8), .RST_PC_VAL(32'h0000_0100)) dut8 (
        .s_clk_i    (clk),
        .s_resetn_i (resetn),
        .bus        (bus8)
    );

    ma_dataphase #(.ERRCNT_W(2), .RST_PC_VAL(32'h0000_0100)) dut2 (
        .s_clk_i    (clk),
        .s_resetn_i (resetn),
        .bus        (bus2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkStall(input string tag, input logic expected);
        @(negedge clk);
        checkOutput(tag, {31'b0, bus8.s_stall_o}, {31'b0, expected});
    endtask

    task automatic applyStimulus(input logic valid, input logic load, input logic store,
                                 input logic [2:0] f, input logic [4:0] rd,
                                 input logic [31:0] val, input logic tstrd);
        bus8.s_exma_valid_i = valid;
        bus8.s_exma_load_i  = load;
        bus8.s_exma_store_i = store;
        bus8.s_exma_f_i     = f;
        bus8.s_exma_rd_i    = rd;
        bus8.s_exma_val_i   = val;
        bus8.s_exma_tstrd_i = tstrd;
    endtask

    task automatic setAhb(input logic hready, input logic hresp, input logic [31:0] hrdata);
        bus8.s_d_hready_i = hready;
        bus8.s_d_hresp_i  = hresp;
        bus8.s_d_hrdata_i = hrdata;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        bus8.s_flush_i    = 1'b0;
        bus8.s_stall_wb_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 1'b0);
        setAhb(1'b1, 1'b0, 32'h0);
        tick();
        tick();

        // Reset state
        checkOutput("rst_valid",  {31'b0, bus8.s_mawb_valid_o}, 32'd0);
        checkOutput("rst_we",     {31'b0, bus8.s_mawb_we_o},    32'd0);
        checkOutput("rst_err",    {31'b0, bus8.s_mawb_err_o},   32'd0);
        checkOutput("rst_rd",     {27'b0, bus8.s_mawb_rd_o},    32'd0);
        checkOutput("rst_val",    bus8.s_mawb_val_o,            32'h0000_0100);
        checkOutput("rst_errcnt", {24'b0, bus8.s_errcnt_o},     32'd0);
        checkOutput("rst_stall",  {31'b0, bus8.s_stall_o},      32'd0);
        resetn = 1'b1;
        tick();

        // ALU result, one-cycle completion, no stall
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b010, 5'd5, 32'h1234_5678, 1'b0);
        checkStall("alu_stall", 1'b0);
        tick();
        checkOutput("alu_valid", {31'b0, bus8.s_mawb_valid_o}, 32'd1);
        checkOutput("alu_we",    {31'b0, bus8.s_mawb_we_o},    32'd1);
        checkOutput("alu_rd",    {27'b0, bus8.s_mawb_rd_o},    32'd5);
        checkOutput("alu_val",   bus8.s_mawb_val_o,            32'h1234_5678);

        // Bubble: valid drops, value holds
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 1'b0);
        tick();
        checkOutput("bubble_valid", {31'b0, bus8.s_mawb_valid_o}, 32'd0);
        checkOutput("bubble_val",   bus8.s_mawb_val_o,            32'h1234_5678);

        // LB at offset 3 with two wait cycles
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 5'd7, 32'h0000_1003, 1'b1);
        setAhb(1'b0, 1'b0, 32'h80FF_FF00);
        checkStall("lb_stall0", 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 5'd7, 32'h0000_1003, 1'b0);
        checkStall("lb_stall1", 1'b1);
        tick();
        setAhb(1'b1, 1'b0, 32'h80FF_FF00);
        checkStall("lb_stall2", 1'b0);
        tick();
        checkOutput("lb_valid", {31'b0, bus8.s_mawb_valid_o}, 32'd1);
        checkOutput("lb_we",    {31'b0, bus8.s_mawb_we_o},    32'd1);
        checkOutput("lb_rd",    {27'b0, bus8.s_mawb_rd_o},    32'd7);
        checkOutput("lb_val",   bus8.s_mawb_val_o,            32'hFFFF_FF80);

        // LHU / LH / LW / LBU, zero-wait
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b101, 5'd8, 32'h0000_1002, 1'b1);
        setAhb(1'b1, 1'b0, 32'h8001_0000);
        checkStall("lhu_stall", 1'b0);
        tick();
        checkOutput("lhu_val", bus8.s_mawb_val_o, 32'h0000_8001);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b001, 5'd8, 32'h0000_1002, 1'b1);
        tick();
        checkOutput("lh_val", bus8.s_mawb_val_o, 32'hFFFF_8001);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 5'd9, 32'h0000_1000, 1'b1);
        tick();
        checkOutput("lw_val", bus8.s_mawb_val_o,         32'h8001_0000);
        checkOutput("lw_rd",  {27'b0, bus8.s_mawb_rd_o}, 32'd9);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b100, 5'd9, 32'h0000_1001, 1'b1);
        setAhb(1'b1, 1'b0, 32'h80FF_FF00);
        tick();
        checkOutput("lbu_val", bus8.s_mawb_val_o, 32'h0000_00FF);

        // Load to x0: valid but no write
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 5'd0, 32'h0000_1000, 1'b1);
        tick();
        checkOutput("x0_valid", {31'b0, bus8.s_mawb_valid_o}, 32'd1);
        checkOutput("x0_we",    {31'b0, bus8.s_mawb_we_o},    32'd0);

        // Successful store
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 5'd3, 32'h3000_0004, 1'b1);
        tick();
        checkOutput("sw_valid", {31'b0, bus8.s_mawb_valid_o}, 32'd1);
        checkOutput("sw_we",    {31'b0, bus8.s_mawb_we_o},    32'd0);
        checkOutput("sw_val",   bus8.s_mawb_val_o,            32'h3000_0004);

        // Store with two-cycle error response
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 5'd3, 32'h2000_0010, 1'b1);
        setAhb(1'b0, 1'b0, 32'h0);
        checkStall("swerr_stall0", 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 5'd3, 32'h2000_0010, 1'b0);
        setAhb(1'b0, 1'b1, 32'h0);
        checkStall("swerr_stall1", 1'b1);
        tick();
        setAhb(1'b1, 1'b1, 32'h0);
        checkStall("swerr_stall2", 1'b0);
        tick();
        checkOutput("swerr_err",    {31'b0, bus8.s_mawb_err_o}, 32'd1);
        checkOutput("swerr_we",     {31'b0, bus8.s_mawb_we_o},  32'd0);
        checkOutput("swerr_val",    bus8.s_mawb_val_o,          32'h2000_0010);
        checkOutput("swerr_cnt8",   {24'b0, bus8.s_errcnt_o},   32'd1);
        checkOutput("swerr_cnt2",   {30'b0, bus2.s_errcnt_o},   32'd1);
        setAhb(1'b1, 1'b0, 32'h0);

        // Flush during DATA: stall held until hready, then dropped
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 5'd4, 32'h0000_1000, 1'b1);
        setAhb(1'b0, 1'b0, 32'hAAAA_5555);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 5'd4, 32'h0000_1000, 1'b0);
        bus8.s_flush_i = 1'b1;
        checkStall("flush_stall0", 1'b1);
        tick();
        bus8.s_flush_i = 1'b0;
        checkStall("flush_stall1", 1'b1);
        tick();
        checkStall("flush_stall2", 1'b1);
        tick();
        setAhb(1'b1, 1'b0, 32'hAAAA_5555);
        checkStall("flush_stall3", 1'b0);
        tick();
        checkOutput("flush_valid", {31'b0, bus8.s_mawb_valid_o}, 32'd0);
        checkOutput("flush_we",    {31'b0, bus8.s_mawb_we_o},    32'd0);
        checkOutput("flush_cnt8",  {24'b0, bus8.s_errcnt_o},     32'd1);

        // WB stall: completed load held internally until WB accepts
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 5'd10, 32'h0000_1000, 1'b1);
        setAhb(1'b1, 1'b0, 32'hCAFE_F00D);
        bus8.s_stall_wb_i = 1'b1;
        checkStall("wbs_stall0", 1'b1);
        tick();
        checkOutput("wbs_hold0", {31'b0, bus8.s_mawb_valid_o}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 5'd10, 32'h0000_1000, 1'b0);
        setAhb(1'b1, 1'b0, 32'h1111_1111);
        tick();
        checkOutput("wbs_hold1", {31'b0, bus8.s_mawb_valid_o}, 32'd0);
        bus8.s_stall_wb_i = 1'b0;
        checkStall("wbs_stall1", 1'b0);
        tick();
        checkOutput("wbs_valid", {31'b0, bus8.s_mawb_valid_o}, 32'd1);
        checkOutput("wbs_val",   bus8.s_mawb_val_o,            32'hCAFE_F00D);
        checkOutput("wbs_rd",    {27'b0, bus8.s_mawb_rd_o},    32'd10);

        // Flush of a non-LSU instruction, and flush coinciding with completion
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 5'd1, 32'h0000_0001, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 5'd1, 32'h0000_0002, 1'b0);
        bus8.s_flush_i = 1'b1;
        tick();
        checkOutput("flalu_valid", {31'b0, bus8.s_mawb_valid_o}, 32'd0);
        bus8.s_flush_i = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 5'd1, 32'h0000_0003, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 5'd6, 32'h0000_1000, 1'b1);
        setAhb(1'b1, 1'b0, 32'h0BAD_0BAD);
        bus8.s_flush_i = 1'b1;
        tick();
        bus8.s_flush_i = 1'b0;
        checkOutput("flcmp_valid", {31'b0, bus8.s_mawb_valid_o}, 32'd0);

        // Three more errors: the 2-bit counter saturates; one is flushed
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 5'd3, 32'h2000_0020 + 32'(i * 4), 1'b1);
            setAhb(1'b0, 1'b1, 32'h0);
            bus8.s_flush_i = (i == 1);
            checkStall("errn_stall", 1'b1);
            tick();
            bus8.s_flush_i = 1'b0;
            applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 5'd3, 32'h2000_0020 + 32'(i * 4), 1'b0);
            setAhb(1'b1, 1'b1, 32'h0);
            tick();
            checkOutput("errn_cnt8",  {24'b0, bus8.s_errcnt_o},     32'(i + 2));
            checkOutput("errn_cnt2",  {30'b0, bus2.s_errcnt_o},     (i == 0) ? 32'd2 : 32'd3);
            checkOutput("errn_valid", {31'b0, bus8.s_mawb_valid_o}, (i == 1) ? 32'd0 : 32'd1);
            setAhb(1'b1, 1'b0, 32'h0);
        end

        // Asynchronous reset in the middle of a data phase
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 5'd2, 32'h0000_0055, 1'b0);
        tick();
        checkOutput("prerst_valid", {31'b0, bus8.s_mawb_valid_o}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 5'd11, 32'h0000_1000, 1'b1);
        setAhb(1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 1'b0);
        #2;
        checkOutput("middata_stall", {31'b0, bus8.s_stall_o}, 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("arst_valid",  {31'b0, bus8.s_mawb_valid_o}, 32'd0);
        checkOutput("arst_val",    bus8.s_mawb_val_o,            32'h0000_0100);
        checkOutput("arst_cnt8",   {24'b0, bus8.s_errcnt_o},     32'd0);
        checkOutput("arst_cnt2",   {30'b0, bus2.s_errcnt_o},     32'd0);
        checkOutput("arst_stall",  {31'b0, bus8.s_stall_o},      32'd0);
        tick();
        resetn = 1'b1;
        checkStall("postrst_stall", 1'b0);
        tick();
        checkOutput("postrst_valid", {31'b0, bus8.s_mawb_valid_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
